// File: rtl/dram_share_sequencer.sv
// dram_share_sequencer: runs one Processor job at a time and arbitrates the
// shared DRAM between the external host port and the Processor. The host owns
// DRAM in IDLE/DONE. A job drains any outstanding host read, then hands DRAM to
// the Processor (sel=1) until it finishes or the watchdog fires. Ownership then
// returns to the host for readback.
module dram_share_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_write,
  output logic              dram_read,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              sel,
  output logic              cpu_enable,
  input  logic              cpu_finish,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SWITCH,
    RUN,
    RELEASE,
    DONE
  } state_t;

  // dram_rdata must carry the read data during the cycle RD_LAT-1 after the
  // read strobe. It is captured on that edge, so host_rvalid lands exactly
  // RD_LAT cycles after the grant.
  localparam logic [2:0]       RdLatInit  = 3'(RD_LAT);
  localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYC);

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                read_q, read_d;
  logic                sel_q, sel_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    runCnt_q, runCnt_d;
  logic                rdPend_q, rdPend_d;
  logic [2:0]          rdCnt_q, rdCnt_d;

  logic                rdFire;
  logic                startAccept;
  logic                hostWindow;
  logic [CNT_W-1:0]    runInc;

  // Next-state logic for the sequencer, the host port and the read tracker.
  // The host grant is decided in RELEASE as well as in IDLE/DONE. Because
  // outputs are registered, the grant strobe then appears in the first DONE
  // cycle, after sel has already returned to the host.
  always_comb begin
    state_d     = state_q;
    gnt_d       = 1'b0;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    done_d      = done_q;
    timeout_d   = timeout_q;
    runCnt_d    = runCnt_q;
    rdPend_d    = rdPend_q;
    rdCnt_d     = rdCnt_q;
    rdFire      = rdPend_q && (rdCnt_q == 3'd1);
    startAccept = start && ((state_q == IDLE) || (state_q == DONE));
    hostWindow  = (state_q == IDLE) || (state_q == DONE) || (state_q == RELEASE);
    runInc      = (runCnt_q == '1) ? runCnt_q : runCnt_q + CNT_W'(1);

    if (rdPend_q) begin
      rdCnt_d = rdCnt_q - 3'd1;
      if (rdFire) begin
        rvalid_d = 1'b1;
        rdata_d  = dram_rdata;
        rdPend_d = 1'b0;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (startAccept) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          runCnt_d  = '0;
          state_d   = rdPend_q ? DRAIN : SWITCH;
        end
      end
      DRAIN: begin
        if (!rdPend_q) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        state_d = RUN;
      end
      RUN: begin
        runCnt_d = runInc;
        if (cpu_finish) begin
          done_d  = 1'b1;
          state_d = RELEASE;
        end else if (runInc >= TimeoutLim) begin
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (hostWindow && !startAccept && host_req && !rdPend_q) begin
      gnt_d   = 1'b1;
      addr_d  = host_addr;
      wdata_d = host_wdata;
      write_d = host_we;
      read_d  = !host_we;
      if (!host_we) begin
        rdPend_d = 1'b1;
        rdCnt_d  = RdLatInit;
      end
    end

    sel_d  = (state_d == SWITCH) || (state_d == RUN);
    en_d   = (state_d == RUN);
    busy_d = (state_d == DRAIN) || (state_d == SWITCH) || (state_d == RUN);
  end

  // Sequencer state register.
  always_ff @(posedge clka) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and read tracker; reset discards any in-flight read.
  always_ff @(posedge clka) begin
    if (reset) begin
      gnt_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      sel_q     <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      runCnt_q  <= '0;
      rdPend_q  <= 1'b0;
      rdCnt_q   <= '0;
    end else begin
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      runCnt_q  <= runCnt_d;
      rdPend_q  <= rdPend_d;
      rdCnt_q   <= rdCnt_d;
    end
  end

  assign host_gnt    = gnt_q;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign dram_addr   = addr_q;
  assign dram_wdata  = wdata_q;
  assign dram_write  = write_q;
  assign dram_read   = read_q;
  assign sel         = sel_q;
  assign cpu_enable  = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign run_cycles  = runCnt_q;

endmodule

// File: tb/tb_dram_share_sequencer.sv
// Testbench for dram_share_sequencer: a host-side DRAM model, a reference
// memory plus job-outcome arithmetic, and a scoreboard monitor for read data.
module tb_dram_share_sequencer;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int RD_LAT      = 3;
  localparam int TIMEOUT_CYC = 120;
  localparam int CNT_W       = 16;

  logic              clka = 1'b0;
  logic              reset, start, host_req, host_we, cpu_finish;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt, host_rvalid, dram_write, dram_read;
  logic              sel, cpu_enable, busy, done, timeout;
  logic [DATA_W-1:0] host_rdata, dram_wdata, dram_rdata;
  logic [ADDR_W-1:0] dram_addr;
  logic [CNT_W-1:0]  run_cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int releaseCyc = 0;

  logic [DATA_W-1:0] dramMem [0:65535];
  logic [DATA_W-1:0] rdPipe [0:RD_LAT-2];
  logic [DATA_W-1:0] refMem [int];
  logic [DATA_W-1:0] expData [$];
  int                expCyc [$];
  logic [ADDR_W-1:0] addrPool [0:7];

  dram_share_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clka(clka), .reset(reset), .start(start),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_write(dram_write), .dram_read(dram_read), .dram_rdata(dram_rdata),
    .sel(sel), .cpu_enable(cpu_enable), .cpu_finish(cpu_finish),
    .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  // Host-side DRAM: writes commit at the edge; read data shows up RD_LAT-1
  // cycles after the strobe and holds garbage otherwise.
  always @(posedge clka) begin
    if (dram_write && !sel) dramMem[dram_addr] <= dram_wdata;
    rdPipe[0] <= dram_read ? dramMem[dram_addr] : DATA_W'($urandom);
    for (int i = 1; i <= RD_LAT - 2; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign dram_rdata = rdPipe[RD_LAT-2];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: pops the expected read data on every rvalid, and
  // watches that grants never happen while a job holds DRAM.
  always @(negedge clka) begin
    logic [DATA_W-1:0] d;
    int c;
    if (host_rvalid) begin
      if (expData.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rvalid_unexpected: rvalid=1 with no read pending");
      end else begin
        d = expData.pop_front();
        c = expCyc.pop_front();
        checkOutput("rdata", 32'(host_rdata), 32'(d));
        checkOutput("rd_latency", cyc - c, RD_LAT);
      end
    end
    if (host_gnt) checkOutput("gnt_owner_busy_sel", {busy, sel}, 0);
    if (sel) checkOutput("pending_reads_at_sel", expData.size(), 0);
  end

  // One host access: hold the request until granted, then model its effect.
  task automatic hostAccess(input bit we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, output int gntCyc);
    bit got = 0;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
    gntCyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clka);
      if (host_gnt) begin got = 1; break; end
    end
    host_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL gnt_timeout: no grant for addr 0x%0h", addr);
    end else begin
      gntCyc = cyc;
      checkOutput("dram_addr", 32'(dram_addr), 32'(addr));
      checkOutput("dram_strobes", {dram_write, dram_read}, we ? 2'b10 : 2'b01);
      if (we) begin
        checkOutput("dram_wdata", 32'(dram_wdata), 32'(data));
        refMem[int'(addr)] = data;
      end else begin
        expData.push_back(refMem.exists(int'(addr)) ? refMem[int'(addr)] : '0);
        expCyc.push_back(cyc);
      end
    end
  endtask

  // One job: finish after n RUN cycles (never if n exceeds the watchdog),
  // optionally with a stray start pulse during RUN.
  task automatic runJob(input int n, input bit extraStart);
    int  k = 0;
    bit  seen = 0;
    bit  prevSel = 0;
    bit  expDone = (n <= TIMEOUT_CYC);
    int  expRun = expDone ? n : TIMEOUT_CYC;
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("flags_cleared", {done, timeout, run_cycles}, 0);
    for (int i = 0; i < 20; i++) begin
      if (cpu_enable) begin seen = 1; break; end
      prevSel = sel;
      @(negedge clka);
    end
    checkOutput("run_entered", seen, 1);
    checkOutput("sel_in_switch", prevSel, 1);
    for (int i = 0; i < TIMEOUT_CYC + 20; i++) begin
      if (!cpu_enable) break;
      k++;
      if (k == n) cpu_finish = 1'b1;
      if (extraStart && k == 3) start = 1'b1;
      @(negedge clka);
      cpu_finish = 1'b0;
      start = 1'b0;
    end
    releaseCyc = cyc;
    checkOutput("enable_cycles", k, expRun);
    checkOutput("release_sel_busy", {sel, busy}, 0);
    checkOutput("done_flag", done, expDone);
    checkOutput("timeout_flag", timeout, !expDone);
    checkOutput("run_cycles", 32'(run_cycles), expRun);
    @(negedge clka);
    cpu_finish = 1'b1;
    @(negedge clka);
    cpu_finish = 1'b0;
    @(negedge clka);
    checkOutput("idle_finish_ignored", {busy, sel, cpu_enable, done, timeout},
                {3'b000, expDone, !expDone});
    checkOutput("idle_run_cycles", 32'(run_cycles), expRun);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clka);
    expData.delete();
    expCyc.delete();
    checkOutput("reset_outputs",
                {host_gnt, host_rvalid, dram_write, dram_read, sel, cpu_enable,
                 busy, done, timeout}, 0);
    checkOutput("reset_values", {host_rdata, dram_wdata, run_cycles}, 0);
    checkOutput("reset_addr", 32'(dram_addr), 0);
    reset = 1'b0;
  endtask

  // Randomized mix of host accesses, write bursts and jobs.
  task automatic applyStimulus(input int iterations);
    int g, prevG;
    for (int it = 0; it < iterations; it++) begin
      case ($urandom_range(0, 3))
        0: hostAccess(1, addrPool[$urandom_range(0, 7)], DATA_W'($urandom), g);
        1: hostAccess(0, addrPool[$urandom_range(0, 7)], '0, g);
        2: begin
          prevG = -1;
          for (int b = 0; b < 4; b++) begin
            hostAccess(1, addrPool[$urandom_range(0, 7)], DATA_W'($urandom), g);
            if (prevG >= 0) checkOutput("write_back_to_back", g - prevG, 1);
            prevG = g;
          end
        end
        default: runJob($urandom_range(1, TIMEOUT_CYC + 30), 1'($urandom));
      endcase
    end
  endtask

  initial begin
    int g;
    start = 0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    cpu_finish = 0;
    for (int i = 0; i < 65536; i++) dramMem[i] = '0;
    for (int i = 0; i < 8; i++) addrPool[i] = ADDR_W'($urandom);
    doReset();

    hostAccess(1, 16'h0010, 8'hA5, g);
    hostAccess(0, 16'h0010, '0, g);
    repeat (RD_LAT + 1) @(negedge clka);

    runJob(100, 0);
    runJob(TIMEOUT_CYC + 10, 0);
    hostAccess(0, 16'h0010, '0, g);
    runJob(TIMEOUT_CYC, 0);
    runJob(1, 1);

    hostAccess(1, 16'h1234, 8'h3C, g);
    hostAccess(0, 16'h1234, '0, g);
    fork
      runJob(40, 1);
      begin
        repeat (10) @(negedge clka);
        hostAccess(0, 16'h1234, '0, g);
      end
    join
    checkOutput("gnt_first_done", g - releaseCyc, 1);
    repeat (RD_LAT + 1) @(negedge clka);

    fork
      runJob(25, 0);
      hostAccess(1, 16'h0042, 8'h99, g);
    join
    checkOutput("start_beats_req", g - releaseCyc, 1);

    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_enable && run_cycles == CNT_W'(19)) break;
      @(negedge clka);
    end
    reset = 1'b1;
    @(negedge clka);
    reset = 1'b0;
    checkOutput("reset_mid_run", {cpu_enable, sel, busy, done, timeout}, 0);
    checkOutput("reset_mid_run_cnt", 32'(run_cycles), 0);
    hostAccess(0, 16'h0042, '0, g);

    applyStimulus(24);
    repeat (RD_LAT + 2) @(negedge clka);
    checkOutput("reads_outstanding", expData.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL sim_timeout: simulation did not complete");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
